// File: rtl/sprite_blit_pkg.sv
// Shared state encoding, screen geometry and bounce helpers for the sprite blitter.
package sprite_blit_pkg;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ERASE, S_MOVE, S_DRAW} blit_state_e;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int INIT_Y   = 52;

  // Direction after a move: flip at the far limit going up, or at zero going down.
  function automatic logic bounce_neg(input int pos, input logic neg, input int lim);
    if (!neg && pos == lim) return 1'b1;
    if (neg && pos == 0) return 1'b0;
    return neg;
  endfunction

  function automatic int bounce_pos(input int pos, input logic neg, input int lim);
    return bounce_neg(pos, neg, lim) ? pos - 1 : pos + 1;
  endfunction

endpackage

// File: rtl/blit_frame_timer.sv
// Free-running animation frame tick; held cleared while the blitter is disabled.
module blit_frame_timer #(
  parameter int FRAME_TICKS = 833334
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)                  cnt_q <= '0;
    else if (!en_i)                cnt_q <= '0;
    else if (cnt_q == '0)          cnt_q <= CW'(FRAME_TICKS - 1);
    else                           cnt_q <= cnt_q - CW'(1);
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/sprite_blit_ctrl.sv
// Bouncing-sprite blitter: erase, move, redraw once per frame tick.
// Define BLIT_TRANSPARENT_EN to suppress writes for ROM pixels that are 0.
module sprite_blit_ctrl
  import sprite_blit_pkg::*;
#(
  parameter int          SPRITE_W    = 16,
  parameter int          SPRITE_H    = 16,
  parameter int          FRAME_TICKS = 833334,
  parameter logic [2:0]  FG_COLOUR   = 3'b111
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       enable,
  output logic [7:0] rom_addr,
  input  logic       rom_q,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  localparam int CXW   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int CYW   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int X_MAX = SCREEN_W - SPRITE_W;
  localparam int Y_MAX = SCREEN_H - SPRITE_H;

  blit_state_e    state_q;
  logic [CXW-1:0] col_q, col_d;
  logic [CYW-1:0] row_q, row_d;
  logic           last_px, tick;
  logic           iss_q, erase_q, draw_vld_q, busy_q, frame_done_q;
  logic           dx_neg_q, dy_neg_q;
  logic [7:0]     x_q, pos_x_q, rom_addr_q;
  logic [6:0]     y_q, pos_y_q;

  blit_frame_timer #(.FRAME_TICKS(FRAME_TICKS)) u_timer (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .en_i     (enable),
    .tick_o   (tick)
  );

  always_comb begin
    last_px = (col_q == CXW'(SPRITE_W - 1)) && (row_q == CYW'(SPRITE_H - 1));
    col_d   = col_q + CXW'(1);
    row_d   = row_q;
    if (col_q == CXW'(SPRITE_W - 1)) begin
      col_d = '0;
      row_d = row_q + CYW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      iss_q        <= 1'b0;
      erase_q      <= 1'b0;
      draw_vld_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      rom_addr_q   <= '0;
      pos_x_q      <= '0;
      pos_y_q      <= 7'(INIT_Y);
      dx_neg_q     <= 1'b0;
      dy_neg_q     <= 1'b1;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (enable) begin
          state_q    <= S_DRAW;
          busy_q     <= 1'b1;
          col_q      <= '0;
          row_q      <= '0;
          rom_addr_q <= '0;
          iss_q      <= 1'b1;
        end
        S_WAIT: begin
          if (!enable) state_q <= S_IDLE;
          else if (tick) begin
            // Erase outputs are loaded on entry so plot is high for the whole state.
            state_q <= S_ERASE;
            busy_q  <= 1'b1;
            erase_q <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
            x_q     <= pos_x_q;
            y_q     <= pos_y_q;
          end
        end
        S_ERASE: begin
          if (last_px) begin
            state_q <= S_MOVE;
            erase_q <= 1'b0;
          end else begin
            col_q <= col_d;
            row_q <= row_d;
            x_q   <= pos_x_q + 8'(col_d);
            y_q   <= pos_y_q + 7'(row_d);
          end
        end
        S_MOVE: begin
          pos_x_q    <= 8'(bounce_pos(int'(pos_x_q), dx_neg_q, X_MAX));
          dx_neg_q   <= bounce_neg(int'(pos_x_q), dx_neg_q, X_MAX);
          pos_y_q    <= 7'(bounce_pos(int'(pos_y_q), dy_neg_q, Y_MAX));
          dy_neg_q   <= bounce_neg(int'(pos_y_q), dy_neg_q, Y_MAX);
          state_q    <= S_DRAW;
          col_q      <= '0;
          row_q      <= '0;
          rom_addr_q <= '0;
          iss_q      <= 1'b1;
        end
        S_DRAW: begin
          // Coordinates trail the address by one cycle to line up with rom_q.
          draw_vld_q <= iss_q;
          x_q        <= pos_x_q + 8'(col_q);
          y_q        <= pos_y_q + 7'(row_q);
          if (iss_q) begin
            if (last_px) iss_q <= 1'b0;
            else begin
              col_q      <= col_d;
              row_q      <= row_d;
              rom_addr_q <= rom_addr_q + 8'd1;
            end
          end else begin
            state_q      <= S_WAIT;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            rom_addr_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr   = rom_addr_q;
  assign x          = x_q;
  assign y          = y_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign colour     = (draw_vld_q && rom_q) ? FG_COLOUR : 3'b000;

`ifdef BLIT_TRANSPARENT_EN
  assign plot = erase_q | (draw_vld_q & rom_q);
`else
  assign plot = erase_q | draw_vld_q;
`endif

endmodule
